// File: rtl/univshift_seq.sv
// Command sequencer driving a univshift register: load/shift commands in, final register value out.
// Define USHIFT_SEQ_CMDQ_EN to add a one-entry pending command slot for back-to-back commands.
module univshift_seq #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic             i_cmd_load,
  input  logic             i_cmd_dir,
  input  logic [CNTW-1:0]  i_cmd_count,
  input  logic [WIDTH-1:0] i_cmd_data,
  input  logic             i_abort,
  output logic [1:0]       o_sr_mode,
  output logic [WIDTH-1:0] o_sr_in,
  input  logic [WIDTH-1:0] i_sr_q,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_res_data
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           r_state, w_next, w_launchState;
  logic             r_dir;
  logic [CNTW-1:0]  r_count, r_cnt;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_srIn, r_res;

  logic             w_accept, w_go, w_launch;
  logic             w_lLoad, w_lDir, w_shiftDir;
  logic [CNTW-1:0]  w_lCount, w_shiftCnt;
  logic [WIDTH-1:0] w_lData;

`ifdef USHIFT_SEQ_CMDQ_EN
  logic             r_pendValid, r_pLoad, r_pDir;
  logic [CNTW-1:0]  r_pCount;
  logic [WIDTH-1:0] r_pData;

  assign o_cmd_ready = !r_pendValid && !i_abort;
`else
  assign o_cmd_ready = (r_state == IDLE) && !i_abort;
`endif

  assign w_accept = i_cmd_valid && o_cmd_ready;

  // A launch starts a new command; it comes from the pending slot when one is waiting.
  always_comb begin
    w_next        = r_state;
    w_launch      = 1'b0;
    w_lLoad       = i_cmd_load;
    w_lDir        = i_cmd_dir;
    w_lCount      = i_cmd_count;
    w_lData       = i_cmd_data;
    w_go          = (r_state == IDLE) && w_accept;
`ifdef USHIFT_SEQ_CMDQ_EN
    if (r_pendValid) begin
      w_lLoad  = r_pLoad;
      w_lDir   = r_pDir;
      w_lCount = r_pCount;
      w_lData  = r_pData;
      w_go     = !i_abort && ((r_state == IDLE) || (r_state == DONE));
    end
`endif
    w_launchState = w_lLoad ? LOAD : ((w_lCount != '0) ? SHIFT : DONE);
    case (r_state)
      IDLE: if (w_go) begin
        w_launch = 1'b1;
        w_next   = w_launchState;
      end
      LOAD:    w_next = i_abort ? IDLE : ((r_count != '0) ? SHIFT : DONE);
      SHIFT:   if (i_abort) w_next = IDLE;
               else if (r_cnt == CNTW'(1)) w_next = DONE;
      DONE: begin
        w_next = IDLE;
        if (w_go) begin
          w_launch = 1'b1;
          w_next   = w_launchState;
        end
      end
      default: w_next = IDLE;
    endcase
    w_shiftDir = w_launch ? w_lDir : r_dir;
    w_shiftCnt = w_launch ? w_lCount : r_count;
  end

  // Mode and data lines are registered from the next state so they line up with that state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_dir   <= 1'b0;
      r_count <= '0;
      r_cnt   <= '0;
      r_mode  <= 2'b00;
      r_srIn  <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_next;
      if (w_launch) begin
        r_dir   <= w_lDir;
        r_count <= w_lCount;
      end
      if ((w_next == SHIFT) && (r_state != SHIFT)) r_cnt <= w_shiftCnt;
      else if (r_state == SHIFT)                    r_cnt <= r_cnt - CNTW'(1);
      case (w_next)
        LOAD: begin
          r_mode <= 2'b11;
          r_srIn <= w_lData;
        end
        SHIFT: begin
          r_mode <= w_shiftDir ? 2'b10 : 2'b01;
          r_srIn <= '0;
        end
        default: begin
          r_mode <= 2'b00;
          r_srIn <= '0;
        end
      endcase
      if (r_state == DONE) r_res <= i_sr_q;
    end
  end

`ifdef USHIFT_SEQ_CMDQ_EN
  // Commands accepted while busy wait here; abort discards them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pendValid <= 1'b0;
      r_pLoad     <= 1'b0;
      r_pDir      <= 1'b0;
      r_pCount    <= '0;
      r_pData     <= '0;
    end else if (i_abort || (w_launch && r_pendValid)) begin
      r_pendValid <= 1'b0;
    end else if (w_accept && (r_state != IDLE)) begin
      r_pendValid <= 1'b1;
      r_pLoad     <= i_cmd_load;
      r_pDir      <= i_cmd_dir;
      r_pCount    <= i_cmd_count;
      r_pData     <= i_cmd_data;
    end
  end
`endif

  assign o_sr_mode  = r_mode;
  assign o_sr_in    = r_srIn;
  assign o_busy     = (r_state != IDLE);
  assign o_done     = (r_state == DONE);
  assign o_res_data = r_res;

endmodule

// File: tb/tb_univshift_seq.sv
// Self-checking bench for univshift_seq with a behavioural univshift register (serial fill 0).
module tb_univshift_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmdValid = 1'b0, cmdLoad = 1'b0, cmdDir = 1'b0, abortIn = 1'b0;
  logic [2:0] cmdCount = '0;
  logic [3:0] cmdData = '0;
  logic       cmdReady, busy, done;
  logic [1:0] srMode;
  logic [3:0] srIn, srQ, resData;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic       load;
    logic       dir;
    logic [2:0] count;
    logic [3:0] data;
    int         lat;
    logic [3:0] res;
    logic [1:0] mode0;
  } vec_t;

  vec_t vecs[7];

  univshift_seq #(.WIDTH(4), .CNTW(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmdValid), .o_cmd_ready(cmdReady),
    .i_cmd_load(cmdLoad), .i_cmd_dir(cmdDir), .i_cmd_count(cmdCount), .i_cmd_data(cmdData),
    .i_abort(abortIn), .o_sr_mode(srMode), .o_sr_in(srIn), .i_sr_q(srQ),
    .o_busy(busy), .o_done(done), .o_res_data(resData)
  );

  always #5 clk = ~clk;

  // Stand-in for the controlled univshift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) srQ <= 4'b0000;
    else case (srMode)
      2'b01:   srQ <= {1'b0, srQ[3:1]};
      2'b10:   srQ <= {srQ[2:0], 1'b0};
      2'b11:   srQ <= srIn;
      default: srQ <= srQ;
    endcase
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic setCmd(input logic v, input logic l, input logic d, input logic [2:0] c, input logic [3:0] x);
    cmdValid = v; cmdLoad = l; cmdDir = d; cmdCount = c; cmdData = x;
  endtask

  // Issue one command from IDLE, then time done, busy and the first mode seen.
  task automatic applyStimulus(input vec_t v, input int idx);
    int n, busyCnt, doneAt;
    logic [1:0] mode0;
    busyCnt = 0;
    doneAt = 0;
    @(negedge clk);
    setCmd(1'b1, v.load, v.dir, v.count, v.data);
    @(negedge clk);
    cmdValid = 1'b0;
    mode0 = srMode;
`ifndef USHIFT_SEQ_CMDQ_EN
    checkOutput($sformatf("v%0d ready_busy", idx), int'(cmdReady), 0);
`endif
    for (n = 1; n <= 40; n++) begin
      if (busy) busyCnt++;
      if (done) begin
        doneAt = n;
        break;
      end
      @(negedge clk);
    end
    checkOutput($sformatf("v%0d latency", idx), doneAt, v.lat);
    checkOutput($sformatf("v%0d busy_cycles", idx), busyCnt, v.lat);
    checkOutput($sformatf("v%0d first_mode", idx), int'(mode0), int'(v.mode0));
    @(negedge clk);
    checkOutput($sformatf("v%0d res_data", idx), int'(resData), int'(v.res));
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 3'd1, 4'b1100, 3, 4'b0110, 2'b11};
    vecs[1] = '{1'b1, 1'b1, 3'd2, 4'b0011, 4, 4'b1100, 2'b11};
    vecs[2] = '{1'b0, 1'b0, 3'd0, 4'b0000, 1, 4'b1100, 2'b00};
    vecs[3] = '{1'b1, 1'b0, 3'd7, 4'b1111, 9, 4'b0000, 2'b11};
    vecs[4] = '{1'b1, 1'b1, 3'd0, 4'b1001, 2, 4'b1001, 2'b11};
    vecs[5] = '{1'b0, 1'b0, 3'd3, 4'b0000, 4, 4'b0001, 2'b01};
    vecs[6] = '{1'b0, 1'b1, 3'd1, 4'b0000, 2, 4'b0010, 2'b10};

    #10 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset sr_mode", int'(srMode), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset res_data", int'(resData), 0);
    checkOutput("reset cmd_ready", int'(cmdReady), 1);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

    // Abort in the second shift cycle: load 1100, then two right shifts leave 0011.
    @(negedge clk);
    setCmd(1'b1, 1'b1, 1'b0, 3'd5, 4'b1100);
    @(negedge clk);
    cmdValid = 1'b0;
    @(negedge clk);
    checkOutput("abort shift1 mode", int'(srMode), 1);
    @(negedge clk);
    abortIn = 1'b1;
    checkOutput("abort shift2 busy", int'(busy), 1);
    @(negedge clk);
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort done", int'(done), 0);
    checkOutput("abort sr_mode", int'(srMode), 0);
    checkOutput("abort res_data", int'(resData), 4'b0010);
    checkOutput("abort blocks ready", int'(cmdReady), 0);
    abortIn = 1'b0;
    #1 checkOutput("ready after abort", int'(cmdReady), 1);
    applyStimulus('{1'b0, 1'b0, 3'd0, 4'b0000, 1, 4'b0011, 2'b00}, 7);

`ifdef USHIFT_SEQ_CMDQ_EN
    // A: load 0011 left 2; B queued during A; C stalls until the slot drains.
    begin
      logic [9:0] doneSeen, readySeen;
      doneSeen = '0;
      readySeen = '0;
      @(negedge clk);
      setCmd(1'b1, 1'b1, 1'b1, 3'd2, 4'b0011);
      for (int n = 1; n <= 9; n++) begin
        @(negedge clk);
        doneSeen[n] = done;
        readySeen[n] = cmdReady;
        if (n == 5) checkOutput("queue res A", int'(resData), 4'b1100);
        if (n == 1)      setCmd(1'b1, 1'b1, 1'b0, 3'd1, 4'b1000);
        else if (n <= 5) setCmd(1'b1, 1'b0, 1'b0, 3'd0, 4'b0000);
        else             cmdValid = 1'b0;
      end
      checkOutput("queue done pattern", int'(doneSeen), int'(10'b01_1001_0000));
      checkOutput("queue ready pattern", int'(readySeen), int'(10'b11_0010_0010));
      checkOutput("queue res C", int'(resData), 4'b0100);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
